// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch stage of the emulated core.
package cpu_pkg;

    localparam int ROM_SIZE = 256;
    localparam int ADDR_W   = $clog2(ROM_SIZE);
    localparam int INSTR_W  = 9;
    localparam logic [INSTR_W-1:0] HALT_INSTR = 9'b111111111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_next_pc.sv
// Next program-counter selection: redirect beats stall beats sequential increment.
module fetch_next_pc
    import cpu_pkg::*;
(
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [ADDR_W-1:0] pc_out_i,
    input  logic              branch_taken_i,
    input  logic              branch_rel_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] branch_off_i,
    input  logic              stall_i,
    output logic [ADDR_W-1:0] next_pc_o
);

    // Relative targets are taken from the word currently in decode; all sums wrap in ADDR_W bits.
    always_comb begin
        next_pc_o = pc_i + ADDR_W'(1);
        if (branch_taken_i) begin
            if (branch_rel_i) begin
                next_pc_o = pc_out_i + branch_off_i;
            end else begin
                next_pc_o = branch_target_i;
            end
        end else if (stall_i) begin
            next_pc_o = pc_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses the instruction ROM and registers the fetched word for decode.
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | fetching one word per cycle (subject to stall/redirect)
//   HALTED | HALT word seen, everything frozen until start
module instr_fetch
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  start_addr,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic               branch_rel,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [ADDR_W-1:0]  branch_off,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               done
);

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  pc_out_q, pc_out_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  next_pc;

    fetch_next_pc u_next_pc (
        .pc_i            (pc_q),
        .pc_out_i        (pc_out_q),
        .branch_taken_i  (branch_taken),
        .branch_rel_i    (branch_rel),
        .branch_target_i (branch_target),
        .branch_off_i    (branch_off),
        .stall_i         (stall),
        .next_pc_o       (next_pc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= '0;
            pc_out_q <= '0;
            instr_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        pc_out_d = pc_out_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        unique case (state_q)
            IDLE, HALTED: begin
                if (start) begin
                    pc_d    = start_addr;
                    valid_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (branch_taken) begin
                    // Word arriving this cycle is on the wrong path; drop it and keep pc_out.
                    pc_d    = next_pc;
                    valid_d = 1'b0;
                end else if (!stall) begin
                    instr_d  = instr_in;
                    pc_out_d = pc_q;
                    if (instr_in == HALT_INSTR) begin
                        valid_d = 1'b0;
                        state_d = HALTED;
                    end else begin
                        valid_d = 1'b1;
                        pc_d    = next_pc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign instr_addr  = pc_q;
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign pc_out      = pc_out_q;
    assign busy        = (state_q == RUN);
    assign done        = (state_q == HALTED);

endmodule
